// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam logic UartIdleLevel = 1'b1;

endpackage

// File: rtl/uart_tx_drain_baud_counter.sv
// Bit-period timer: counts clock cycles while enabled and pulses bit_done on
// the final cycle of each bit period. Shared between UART transmit and receive.
module baud_counter #(
  parameter int ClocksPerBit = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CountWidth = $clog2(ClocksPerBit);
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(ClocksPerBit - 1);

  logic [CountWidth-1:0] count;

  assign bit_done = enable && (count == LastCount);

  // Wraps to zero at each bit boundary; clear lets a new frame start on a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LastCount) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Drains a ring buffer onto an 8N1 UART line, fetching the next word at the end of
// each stop bit so consecutive frames are separated only by the fetch/latch cycles.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int WordLengthBits = 8,
  parameter int ClocksPerBit   = 868
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      buffer_empty,
  input  logic [WordLengthBits-1:0] data_in,
  input  logic                      data_in_valid,
  output logic                      get,
  output logic                      tx,
  output logic                      busy
);

  localparam int BitCountWidth = (WordLengthBits > 1) ? $clog2(WordLengthBits) : 1;
  localparam logic [BitCountWidth-1:0] LastBit = BitCountWidth'(WordLengthBits - 1);

  uart_tx_state_t            state;
  logic [WordLengthBits-1:0] shift_reg;
  logic [BitCountWidth-1:0]  bit_cnt;
  logic                      baud_enable;
  logic                      baud_clear;
  logic                      bit_done;

  assign baud_enable = (state == START) || (state == DATA) || (state == STOP);
  assign baud_clear  = (state == LATCH);

  baud_counter #(
    .ClocksPerBit(ClocksPerBit)
  ) u_baud_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .enable  (baud_enable),
    .bit_done(bit_done)
  );

  // Single FSM owning every output; get is a one-cycle pulse and defaults low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      get       <= 1'b0;
      tx        <= UartIdleLevel;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      get <= 1'b0;
      case (state)
        IDLE: begin
          tx <= UartIdleLevel;
          if (!buffer_empty) begin
            state <= FETCH;
            get   <= 1'b1;
            busy  <= 1'b1;
          end
        end

        FETCH: begin
          state <= LATCH;
        end

        // A missing valid here means the buffer lied about being non-empty; drop back quietly.
        LATCH: begin
          if (data_in_valid) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
            tx        <= 1'b0;
            state     <= START;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= DATA;
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_cnt == LastBit) begin
              tx    <= UartIdleLevel;
              state <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end

        // Empty flag changes mid-frame only matter here, on the final stop cycle.
        STOP: begin
          if (bit_done) begin
            if (!buffer_empty) begin
              state <= FETCH;
              get   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          tx    <= UartIdleLevel;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain: a queue-based ring buffer upstream, a
// frame-timeline reference model compared every cycle, and a UART line decoder.
module tb_uart_tx_drain;

  localparam int W           = 8;
  localparam int CPB         = 4;
  localparam int FrameCycles = (W + 2) * CPB;
  localparam int LastPhase   = 1 + FrameCycles;
  localparam int FramePeriod = FrameCycles + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         buffer_empty;
  logic [W-1:0] data_in;
  logic         data_in_valid;
  logic         get;
  logic         tx;
  logic         busy;

  logic         put = 1'b0;
  logic [W-1:0] put_data = '0;
  logic         stub_mode = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_valid = 1'b0;
  logic [W-1:0] fifo_data = '0;
  logic [W-1:0] fifo[$];

  logic [W-1:0] put_log[$];
  logic [W-1:0] exp_frames[$];
  logic [W-1:0] decoded_log[$];
  int           start_times[$];

  bit           m_active = 1'b0;
  int           m_phase = 0;
  int           m_idx = 0;
  logic [W-1:0] m_byte = '0;

  bit           dec_busy = 1'b0;
  int           dec_cnt = 0;
  logic [9:0]   dec_raw = '0;
  logic [9:0]   last_raw = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int get_count = 0;
  int busy_cycles = 0;

  assign buffer_empty  = stub_mode ? 1'b0 : fifo_empty;
  assign data_in_valid = stub_mode ? 1'b0 : fifo_valid;
  assign data_in       = fifo_data;

  uart_tx_drain #(
    .WordLengthBits(W),
    .ClocksPerBit  (CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buffer_empty (buffer_empty),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .get          (get),
    .tx           (tx),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Ring buffer stand-in: one-cycle read latency, registered empty flag.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      fifo.delete();
      fifo_empty <= 1'b1;
      fifo_valid <= 1'b0;
    end else begin
      if (get && fifo.size() > 0) begin
        fifo_data  <= fifo.pop_front();
        fifo_valid <= 1'b1;
      end else begin
        fifo_valid <= 1'b0;
      end
      if (put && fifo.size() < 128) fifo.push_back(put_data);
      fifo_empty <= (fifo.size() == 0);
    end
  end

  // Reference model: phase 0 is the fetch cycle, 1 the latch, 2..LastPhase the frame.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 1'b0;
      m_phase  = 0;
      exp_frames.delete();
    end else if (!m_active) begin
      if (!buffer_empty) begin
        m_active = 1'b1;
        m_phase  = 0;
      end
    end else if (m_phase == 1) begin
      if (data_in_valid) begin
        m_byte = put_log[m_idx];
        m_idx++;
        exp_frames.push_back(m_byte);
        m_phase = 2;
      end else begin
        m_active = 1'b0;
      end
    end else if (m_phase == LastPhase) begin
      if (!buffer_empty) m_phase = 0;
      else m_active = 1'b0;
    end else begin
      m_phase++;
    end
  end

  function automatic logic expectedTx();
    int slot;
    if (!m_active || m_phase < 2) return 1'b1;
    slot = (m_phase - 2) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= W) return m_byte[slot-1];
    return 1'b1;
  endfunction

  initial forever begin
    @(negedge clk);
    checkOutput("cycle_outputs", 32'({get, tx, busy}),
                32'({(m_active && m_phase == 0), expectedTx(), m_active}));
  end

  initial forever begin
    @(negedge clk);
    if (get === 1'b1) get_count++;
    if (busy === 1'b1) busy_cycles++;
  end

  // Line decoder: samples each bit mid-period and checks frames against the model's order.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      dec_busy = 1'b0;
    end else begin
      if (!dec_busy) begin
        if (tx === 1'b0) begin
          dec_busy = 1'b1;
          dec_cnt  = 0;
          dec_raw  = '0;
          start_times.push_back(cyc);
        end
      end else begin
        dec_cnt++;
      end
      if (dec_busy) begin
        if (dec_cnt % CPB == CPB / 2) dec_raw[dec_cnt/CPB] = tx;
        if (dec_cnt == FrameCycles - 1) begin
          dec_busy = 1'b0;
          last_raw = dec_raw;
          decoded_log.push_back(dec_raw[8:1]);
          checkOutput("frame_start_stop", 32'({dec_raw[9], dec_raw[0]}), 32'h2);
          if (exp_frames.size() == 0) checkOutput("frame_expected", 32'd0, 32'd1);
          else checkOutput("frame_data", 32'(dec_raw[8:1]), 32'(exp_frames.pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] value);
    @(negedge clk);
    put      = 1'b1;
    put_data = value;
    put_log.push_back(value);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      put = 1'b0;
    end
  endtask

  task automatic waitIdle(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      put = 1'b0;
      if (!busy && buffer_empty && !dec_busy) done = 1'b1;
    end
    checkOutput("wait_idle", 32'(done), 32'd1);
  endtask

  task automatic clearStats();
    get_count   = 0;
    busy_cycles = 0;
    decoded_log.delete();
    start_times.delete();
  endtask

  task automatic midFrameReset(input logic [W-1:0] value, input int bit_idx);
    bit hit = 1'b0;
    int g = 0;
    int t = 0;
    applyStimulus(value);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      put = 1'b0;
      if (dec_busy && dec_cnt == (bit_idx + 1) * CPB + 1) hit = 1'b1;
    end
    checkOutput("midframe_reached", 32'(hit), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset_outputs", 32'({get, tx, busy}), 32'b010);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (get) g++;
      if (!tx) t++;
    end
    checkOutput("post_reset_get", 32'(g), 32'd0);
    checkOutput("post_reset_tx_low", 32'(t), 32'd0);
  endtask

  initial begin
    logic       seq[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [9:0] exp_raw;
    int         bad;
    int         g;
    int         t;

    // Reset held with writes attempted: line must stay idle.
    repeat (20) begin
      @(negedge clk);
      put      = 1'b1;
      put_data = 8'hAA;
      checkOutput("reset_idle", 32'({get, tx, busy}), 32'b010);
    end
    @(negedge clk);
    put = 1'b0;
    rst = 1'b0;
    idleCycles(5);

    $display("[TB] single byte");
    clearStats();
    applyStimulus(8'hA5);
    waitIdle(200);
    for (int i = 0; i < 10; i++) exp_raw[i] = seq[i];
    checkOutput("single_raw", 32'(last_raw), 32'(exp_raw));
    checkOutput("single_get_count", 32'(get_count), 32'd1);
    checkOutput("single_busy_cycles", 32'(busy_cycles), 32'(FramePeriod));
    checkOutput("single_empty", 32'(buffer_empty), 32'd1);
    checkOutput("single_frames", 32'(decoded_log.size()), 32'd1);

    $display("[TB] back-to-back");
    idleCycles(3);
    clearStats();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h55);
    waitIdle(400);
    checkOutput("b2b_get_count", 32'(get_count), 32'd3);
    checkOutput("b2b_frames", 32'(decoded_log.size()), 32'd3);
    if (decoded_log.size() == 3)
      checkOutput("b2b_order", 32'({decoded_log[0], decoded_log[1], decoded_log[2]}), 32'h0000FF55);
    if (start_times.size() == 3) begin
      checkOutput("b2b_spacing_1", 32'(start_times[1] - start_times[0]), 32'(FramePeriod));
      checkOutput("b2b_spacing_2", 32'(start_times[2] - start_times[1]), 32'(FramePeriod));
    end

    $display("[TB] fill and drain");
    idleCycles(3);
    clearStats();
    for (int i = 0; i < 128; i++) applyStimulus(8'(i));
    waitIdle(8000);
    bad = 0;
    foreach (decoded_log[i]) if (decoded_log[i] !== 8'(i)) bad++;
    checkOutput("fill_frames", 32'(decoded_log.size()), 32'd128);
    checkOutput("fill_order", 32'(bad), 32'd0);
    checkOutput("fill_get_count", 32'(get_count), 32'd128);
    checkOutput("fill_busy_cycles", 32'(busy_cycles), 32'(128 * FramePeriod));
    if (start_times.size() == 128)
      checkOutput("fill_span", 32'(start_times[127] - start_times[0]), 32'(127 * FramePeriod));
    checkOutput("fill_empty", 32'(buffer_empty), 32'd1);

    $display("[TB] randomized traffic");
    idleCycles(3);
    clearStats();
    for (int n = 0; n < 40; n++) begin
      int gap;
      applyStimulus(8'($urandom));
      gap = $urandom_range(0, 50);
      if (gap > 0) idleCycles(gap);
    end
    waitIdle(3000);
    checkOutput("random_frames", 32'(decoded_log.size()), 32'd40);
    checkOutput("random_get_count", 32'(get_count), 32'd40);

    $display("[TB] asynchronous reset mid-frame");
    idleCycles(3);
    midFrameReset(8'h0F, 3);
    midFrameReset(8'h0F, 5);

    $display("[TB] latch without valid data");
    @(posedge clk);
    #2 rst = 1'b1;
    stub_mode = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    g = 0;
    t = 0;
    repeat (30) begin
      @(negedge clk);
      if (get) g++;
      if (!tx) t++;
    end
    checkOutput("defensive_get_count", 32'(g), 32'd10);
    checkOutput("defensive_tx_low", 32'(t), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    stub_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idleCycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
